// File: rtl/uart_tx_pkt_arbiter.sv
// uart_tx_pkt_arbiter
//
// Shares one UART transmitter between two byte requesters. Each accepted byte
// goes out as a two-byte packet: HEADER_BYTE, then the payload. Requesters are
// served round-robin. A watchdog aborts a packet whose tx_done edge never
// arrives, so the transmitter cannot be locked up.
//
// Ports:
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_reqN_valid/_byte     requester N offers a byte (held until accepted)
//   o_reqN_ready           requester N byte taken this cycle (combinational)
//   o_tx_dv, o_tx_byte     start pulse and byte to the UART TX
//   i_tx_active, i_tx_done UART TX busy / byte complete
//   o_busy                 packet in flight
//   o_grant                requester owning the current or last packet
//   o_timeout              one-cycle pulse when the watchdog drops a packet
module uart_tx_pkt_arbiter #(
  parameter logic [7:0]  HEADER_BYTE    = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_byte,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_byte,
  output logic       o_req1_ready,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_busy,
  output logic       o_grant,
  output logic       o_timeout
);

  localparam logic [31:0] WdogLast = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitHdr,
    StSendData,
    StWaitData
  } state_e;

  state_e      state_q, state_d;
  logic        rr_pri_q, rr_pri_d;
  logic        prev_done_q;
  logic [31:0] wdog_q, wdog_d;
  logic [7:0]  payload_q, payload_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_dv_q, tx_dv_d;
  logic        grant_q, grant_d;
  logic        timeout_q, timeout_d;

  logic sel;
  logic can_accept;
  logic accept;
  logic done_edge;
  logic wdog_expired;

  // Lone requester wins outright; a tie goes to the round-robin pointer.
  always_comb begin
    if (i_req0_valid && i_req1_valid) begin
      sel = rr_pri_q;
    end else begin
      sel = i_req1_valid;
    end
  end

  assign can_accept   = (state_q == StIdle) && !i_tx_active && !i_rst;
  assign o_req0_ready = can_accept && !sel && i_req0_valid;
  assign o_req1_ready = can_accept && sel && i_req1_valid;
  assign accept       = o_req0_ready || o_req1_ready;

  // A done level left high from the previous byte must not count again.
  assign done_edge    = i_tx_done && !prev_done_q;
  assign wdog_expired = (wdog_q == WdogLast);

  always_comb begin
    state_d   = state_q;
    rr_pri_d  = rr_pri_q;
    payload_d = payload_q;
    tx_byte_d = tx_byte_q;
    tx_dv_d   = 1'b0;
    grant_d   = grant_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          payload_d = sel ? i_req1_byte : i_req0_byte;
          grant_d   = sel;
          rr_pri_d  = ~sel;
          tx_dv_d   = 1'b1;
          tx_byte_d = HEADER_BYTE;
          state_d   = StWaitHdr;
        end
      end
      StWaitHdr: begin
        if (done_edge) begin
          state_d = StSendData;
        end else if (wdog_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StSendData: begin
        if (!i_tx_active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = payload_q;
          state_d   = StWaitData;
        end
      end
      StWaitData: begin
        if (done_edge) begin
          state_d = StIdle;
        end else if (wdog_expired) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
    endcase
  end

  // Watchdog restarts on every state change and only runs while waiting for done.
  always_comb begin
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == StWaitHdr) || (state_q == StWaitData)) begin
      wdog_d = wdog_q + 32'd1;
    end else begin
      wdog_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      rr_pri_q    <= 1'b0;
      prev_done_q <= 1'b0;
      wdog_q      <= '0;
      payload_q   <= 8'h00;
      tx_byte_q   <= 8'h00;
      tx_dv_q     <= 1'b0;
      grant_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_pri_q    <= rr_pri_d;
      prev_done_q <= i_tx_done;
      wdog_q      <= wdog_d;
      payload_q   <= payload_d;
      tx_byte_q   <= tx_byte_d;
      tx_dv_q     <= tx_dv_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
    end
  end

  // Gate the start pulse so the UART never sees a start while reset is applied.
  assign o_tx_dv   = tx_dv_q && !i_rst;
  assign o_tx_byte = tx_byte_q;
  assign o_busy    = (state_q != StIdle);
  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_pkt_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_pkt_arbiter;

  localparam logic [7:0]  Hdr = 8'hAA;
  localparam int unsigned Tmo = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_byte = 8'h00, req1_byte = 8'h00;
  logic       req0_ready, req1_ready;
  logic       tx_dv, tx_active = 1'b0, tx_done = 1'b0;
  logic [7:0] tx_byte;
  logic       busy, grant, timeout;

  always #5 clk = ~clk;

  uart_tx_pkt_arbiter #(
    .HEADER_BYTE   (Hdr),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0_valid(req0_valid),
    .i_req0_byte (req0_byte),
    .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid),
    .i_req1_byte (req1_byte),
    .o_req1_ready(req1_ready),
    .o_tx_dv     (tx_dv),
    .o_tx_byte   (tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (tx_done),
    .o_busy      (busy),
    .o_grant     (grant),
    .o_timeout   (timeout)
  );

  int cyc = 0;
  int n_checks = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester queues and UART model state
  logic [7:0] q0[$], q1[$];
  bit  pop0, pop1, dv_seen;
  int  u_cnt = 0, done_left = 0, bt = 10, done_len = 1;
  bit  u_act, force_act, drop_done, rand_mode;

  // Reference model: packet progress 0 idle, 1 header out, 2 payload pending, 3 payload out
  int         m_stage = 0, m_deadline = 0;
  bit         m_rr, m_grant, m_prev, m_dv_due, m_to_due, after_rst, win, edge_now, exp_r0, exp_r1;
  logic [7:0] m_payload = 8'h00, m_byte = 8'h00, m_byte_due = 8'h00;
  logic [7:0] tx_log[$];
  int         dv_cyc_log[$];
  int         n_acc0 = 0, n_acc1 = 0, n_to = 0, last_to_cyc = 0;

  // Drivers: requesters and UART, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (pop0) begin void'(q0.pop_front()); pop0 = 0; end
    if (pop1) begin void'(q1.pop_front()); pop1 = 0; end
    req0_valid = (q0.size() != 0);
    req0_byte  = (q0.size() != 0) ? q0[0] : 8'h00;
    req1_valid = (q1.size() != 0);
    req1_byte  = (q1.size() != 0) ? q1[0] : 8'h00;
    if (rst) begin
      u_cnt = 0; u_act = 0; done_left = 0;
    end else begin
      if (done_left > 0) done_left--;
      if (dv_seen) begin
        u_cnt = rand_mode ? int'($urandom_range(3, 40)) : bt;
        u_act = 1;
      end else if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          u_act = 0;
          if (!drop_done && !(rand_mode && $urandom_range(0, 31) == 0))
            done_left = rand_mode ? int'($urandom_range(1, 3)) : done_len;
        end
      end
    end
    tx_done   = (done_left > 0);
    tx_active = u_act | force_act;
  end

  // Monitor and reference model, sampled on the falling edge.
  always @(negedge clk) begin
    dv_seen = 0;
    if (rst) begin
      check_eq("rst_ready0", req0_ready, 0);
      check_eq("rst_ready1", req1_ready, 0);
      check_eq("rst_dv", tx_dv, 0);
      m_stage = 0; m_rr = 0; m_grant = 0; m_prev = 0; m_dv_due = 0; m_to_due = 0;
      m_byte = 8'h00; after_rst = 1;
    end else begin
      if (after_rst) begin
        check_eq("post_rst_outs", {tx_dv, busy, grant, timeout, tx_byte}, 0);
        after_rst = 0;
      end
      if (m_dv_due) m_byte = m_byte_due;
      check_eq("busy", busy, m_stage != 0);
      check_eq("dv", tx_dv, m_dv_due);
      check_eq("tx_byte", tx_byte, m_byte);
      check_eq("timeout", timeout, m_to_due);
      check_eq("grant", grant, m_grant);
      if (tx_dv) begin
        tx_log.push_back(tx_byte); dv_cyc_log.push_back(cyc); dv_seen = 1;
      end
      if (timeout) begin n_to++; last_to_cyc = cyc; end
      edge_now = tx_done && !m_prev;
      exp_r0 = 0; exp_r1 = 0; m_dv_due = 0; m_to_due = 0;
      case (m_stage)
        0: if (!tx_active && (req0_valid || req1_valid)) begin
          win = (req0_valid && req1_valid) ? m_rr : req1_valid;
          exp_r0 = !win; exp_r1 = win;
          m_grant = win; m_rr = !win;
          m_payload = win ? req1_byte : req0_byte;
          m_dv_due = 1; m_byte_due = Hdr;
          m_deadline = cyc + 1 + Tmo; m_stage = 1;
          if (win) begin pop1 = 1; n_acc1++; end else begin pop0 = 1; n_acc0++; end
        end
        1, 3: if (edge_now) m_stage = (m_stage == 1) ? 2 : 0;
              else if (cyc == m_deadline - 1) begin m_to_due = 1; m_stage = 0; end
        2: if (!tx_active) begin
          m_dv_due = 1; m_byte_due = m_payload;
          m_deadline = cyc + 1 + Tmo; m_stage = 3;
        end
        default: m_stage = 0;
      endcase
      check_eq("ready0", req0_ready, exp_r0);
      check_eq("ready1", req1_ready, exp_r1);
    end
    m_prev = rst ? 1'b0 : tx_done;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; step(2); rst = 0; step(1);
  endtask

  task automatic wait_quiet(input string tag, input int bound);
    int k = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && m_stage == 0 && u_cnt == 0 &&
             done_left == 0 && !pop0 && !pop1) && k < bound) begin
      step(1); k++;
    end
    check_eq({tag, "_bound"}, k < bound, 1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [7:0] b);
    if (tx_log.size() > idx) check_eq(tag, tx_log[idx], b);
    else check_eq({tag, "_missing"}, tx_log.size(), idx + 1);
  endtask

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 3) == 0) ? Hdr : 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int s, a0, k, rel, pushes;
    step(3); rst = 0; step(2);

    // Single packet with realistic byte time
    bt = 2170; s = tx_log.size(); a0 = n_acc0;
    q0.push_back(8'h37);
    wait_quiet("t1", 10000);
    check_eq("t1_len", tx_log.size(), s + 2);
    check_log("t1_hdr", s, Hdr);
    check_log("t1_pl", s + 1, 8'h37);
    check_eq("t1_acc", n_acc0 - a0, 1);
    bt = 10;

    // Both requesters continuously valid from reset
    do_reset(); s = tx_log.size();
    q0.push_back(8'h11); q0.push_back(8'h11);
    q1.push_back(8'h22); q1.push_back(8'h22);
    wait_quiet("t2", 2000);
    check_eq("t2_len", tx_log.size(), s + 8);
    for (int i = 0; i < 4; i++) begin
      check_log("t2_hdr", s + 2 * i, Hdr);
      check_log("t2_pl", s + 2 * i + 1, (i % 2 == 0) ? 8'h11 : 8'h22);
    end

    // Payload equal to the header byte
    s = tx_log.size();
    q1.push_back(Hdr);
    wait_quiet("t3", 1000);
    check_log("t3_hdr", s, Hdr);
    check_log("t3_pl", s + 1, Hdr);

    // Header done never arrives; next pending byte goes after the abort
    s = tx_log.size(); a0 = n_to; drop_done = 1;
    q0.push_back(8'h99); q0.push_back(8'h42);
    k = 0;
    while (n_to == a0 && k < Tmo + 200) begin step(1); k++; end
    check_eq("t4_to_seen", n_to - a0, 1);
    drop_done = 0;
    wait_quiet("t4", 1000);
    check_eq("t4_len", tx_log.size(), s + 3);
    check_log("t4_hdr0", s, Hdr);
    check_log("t4_hdr1", s + 1, Hdr);
    check_log("t4_pl", s + 2, 8'h42);
    if (dv_cyc_log.size() >= s + 2) begin
      check_eq("t4_to_latency", last_to_cyc - dv_cyc_log[s], Tmo);
      check_eq("t4_next_accept", dv_cyc_log[s + 1], last_to_cyc + 1);
    end

    // Transmitter busy while idle: nothing accepted
    a0 = n_acc0; force_act = 1;
    q0.push_back(8'h77);
    step(10);
    check_eq("t5_no_accept", n_acc0 - a0, 0);
    force_act = 0;
    wait_quiet("t5", 1000);

    // Transmitter held busy in the payload-send phase
    s = tx_log.size();
    q0.push_back(8'h3C);
    k = 0;
    while (!tx_done && k < 200) begin step(1); k++; end
    check_eq("t6_hdr_done", tx_done, 1);
    force_act = 1;
    step(50);
    force_act = 0; rel = cyc + 1;
    wait_quiet("t6", 1000);
    check_log("t6_pl", s + 1, 8'h3C);
    if (dv_cyc_log.size() >= s + 2) check_eq("t6_dv_delay", dv_cyc_log[s + 1], rel + 1);

    // Reset while the payload is in flight, then a clean packet
    q0.push_back(8'h66);
    k = 0;
    while (m_stage != 3 && k < 500) begin step(1); k++; end
    check_eq("t7_in_wait_data", m_stage, 3);
    step(3);
    rst = 1; step(1); rst = 0; step(1);
    s = tx_log.size();
    q0.push_back(8'h5A);
    wait_quiet("t7", 1000);
    check_eq("t7_len", tx_log.size(), s + 2);
    check_log("t7_hdr", s, Hdr);
    check_log("t7_pl", s + 1, 8'h5A);

    // Randomized traffic, byte times, done widths, stalls and dropped dones
    rand_mode = 1; pushes = 0; a0 = n_acc0 + n_acc1;
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 7) == 0) begin q0.push_back(rand_byte()); pushes++; end
      if (q1.size() < 3 && $urandom_range(0, 7) == 0) begin q1.push_back(rand_byte()); pushes++; end
      if ($urandom_range(0, 24) == 0) force_act = !force_act;
      step(1);
    end
    force_act = 0;
    wait_quiet("rand", 20000);
    rand_mode = 0;
    check_eq("rand_accepted", n_acc0 + n_acc1 - a0, pushes);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL global_time_limit: got cycle %0d expected finish earlier", cyc);
    $fatal(1);
  end

endmodule
